// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing from the pixel clock.
// Ports: vga_clk/reset in; DrawX/DrawY/blank/hs/vs/line_end/frame_start/frame_count out.
module vga_timing_gen #(
  parameter int unsigned H_VISIBLE = 640,
  parameter int unsigned H_FRONT   = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BACK    = 48,
  parameter int unsigned V_VISIBLE = 480,
  parameter int unsigned V_FRONT   = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BACK    = 33,
  parameter int unsigned SYNC_POL  = 0
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_end,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
  localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  localparam logic ACT  = 1'(SYNC_POL);
  localparam logic IDLE = ~ACT;

  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       blank_q, blank_d;
  logic       hs_q, hs_d;
  logic       vs_q, vs_d;
  logic       le_q, le_d;
  logic       fs_q, fs_d;
  logic [7:0] fc_q, fc_d;

  logic h_wrap;
  logic f_wrap;

  // Every output is decoded from the next counter values so that all
  // registered outputs describe the same (DrawX,DrawY) point.
  always_comb begin
    h_wrap = (x_q == H_LAST);
    f_wrap = h_wrap && (y_q == V_LAST);

    x_d = h_wrap ? 10'd0 : x_q + 10'd1;
    y_d = y_q;
    if (h_wrap) begin
      y_d = f_wrap ? 10'd0 : y_q + 10'd1;
    end

    blank_d = (x_d < H_VIS) && (y_d < V_VIS);
    hs_d    = (x_d >= HS_BEG && x_d < HS_END) ? ACT : IDLE;
    vs_d    = (y_d >= VS_BEG && y_d < VS_END) ? ACT : IDLE;
    le_d    = (x_d == H_LAST);
    fs_d    = f_wrap;
    fc_d    = fc_q + {7'd0, f_wrap};

    if (reset) begin
      x_d     = 10'd0;
      y_d     = 10'd0;
      blank_d = 1'b1;
      hs_d    = IDLE;
      vs_d    = IDLE;
      le_d    = 1'b0;
      fs_d    = 1'b0;
      fc_d    = 8'd0;
    end
  end

  always_ff @(posedge vga_clk) begin
    x_q     <= x_d;
    y_q     <= y_d;
    blank_q <= blank_d;
    hs_q    <= hs_d;
    vs_q    <= vs_d;
    le_q    <= le_d;
    fs_q    <= fs_d;
    fc_q    <= fc_d;
  end

  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign blank       = blank_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign line_end    = le_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: checks three vga_timing_gen configs against a
// cycle-index raster model, a constant vector table and window counts.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       le;
    logic       fs;
    logic [7:0] fc;
  } obs_t;

  typedef struct {
    int hv, hf, hsw, hb;
    int vv, vf, vsw, vb;
    int pol;
  } cfg_t;

  typedef struct {
    int   inst;
    int   k;
    obs_t exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst [3];
  obs_t obs [3];
  cfg_t cfg [3];
  int   k   [3];

  logic [9:0] x0, y0, x1, y1, x2, y2;
  logic b0, h0, v0, l0, f0;
  logic b1, h1, v1, l1, f1;
  logic b2, h2, v2, l2, f2;
  logic [7:0] c0, c1, c2;

  vga_timing_gen u0 (
    .vga_clk(clk), .reset(rst[0]), .DrawX(x0), .DrawY(y0),
    .blank(b0), .hs(h0), .vs(v0), .line_end(l0),
    .frame_start(f0), .frame_count(c0));

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .SYNC_POL(0)
  ) u1 (
    .vga_clk(clk), .reset(rst[1]), .DrawX(x1), .DrawY(y1),
    .blank(b1), .hs(h1), .vs(v1), .line_end(l1),
    .frame_start(f1), .frame_count(c1));

  vga_timing_gen #(
    .H_VISIBLE(320), .V_VISIBLE(240), .SYNC_POL(1)
  ) u2 (
    .vga_clk(clk), .reset(rst[2]), .DrawX(x2), .DrawY(y2),
    .blank(b2), .hs(h2), .vs(v2), .line_end(l2),
    .frame_start(f2), .frame_count(c2));

  assign obs[0] = {x0, y0, b0, h0, v0, l0, f0, c0};
  assign obs[1] = {x1, y1, b1, h1, v1, l1, f1, c1};
  assign obs[2] = {x2, y2, b2, h2, v2, l2, f2, c2};

  int compared   = 0;
  int mismatched = 0;

  obs_t sbq [$];
  vec_t tbl [$];

  bit phase_a = 1'b1;
  int hs0_act = 0, bl0 = 0, le0 = 0;
  int hs2_act = 0, bl2 = 0;
  int vs1_act = 0, bl1 = 0;
  int fs_cnt = 0, fs_last = -1;

  function automatic obs_t mk(int x, int y, int b, int hs, int vs,
                              int le, int fs, int fc);
    obs_t o;
    o.x = 10'(x); o.y = 10'(y);
    o.blank = 1'(b); o.hs = 1'(hs); o.vs = 1'(vs);
    o.le = 1'(le); o.fs = 1'(fs); o.fc = 8'(fc);
    return o;
  endfunction

  // Expected point after k clocks since reset release.
  function automatic obs_t model(int i, int kk);
    cfg_t c = cfg[i];
    int ht = c.hv + c.hf + c.hsw + c.hb;
    int vt = c.vv + c.vf + c.vsw + c.vb;
    int ft = ht * vt;
    int x = kk % ht;
    int y = (kk / ht) % vt;
    int hsa = (x >= c.hv + c.hf) && (x < c.hv + c.hf + c.hsw);
    int vsa = (y >= c.vv + c.vf) && (y < c.vv + c.vf + c.vsw);
    return mk(x, y, (x < c.hv) && (y < c.vv),
              hsa ? c.pol : 1 - c.pol, vsa ? c.pol : 1 - c.pol,
              x == ht - 1, (kk > 0) && (kk % ft == 0),
              (kk / ft) % 256);
  endfunction

  task automatic chk(string name, int got, int want);
    compared++;
    if (got != want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic step();
    obs_t e;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (rst[i]) k[i] = 0;
      else k[i]++;
      sbq.push_back(model(i, k[i]));
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      e = sbq.pop_front();
      compared++;
      if (obs[i] !== e) begin
        mismatched++;
        $display("FAIL model u%0d k=%0d: got %h want %h",
                 i, k[i], obs[i], e);
      end
    end
    foreach (tbl[j]) begin
      if (k[tbl[j].inst] == tbl[j].k) begin
        compared++;
        if (obs[tbl[j].inst] !== tbl[j].exp) begin
          mismatched++;
          $display("FAIL vec%0d u%0d k=%0d: got %h want %h", j,
                   tbl[j].inst, tbl[j].k, obs[tbl[j].inst], tbl[j].exp);
        end
      end
    end
    if (phase_a) begin
      if (k[0] >= 800 && k[0] < 1600) begin
        hs0_act += (obs[0].hs == 1'b0);
        bl0 += obs[0].blank;
        le0 += obs[0].le;
      end
      if (k[2] >= 480 && k[2] < 960) begin
        hs2_act += (obs[2].hs == 1'b1);
        bl2 += obs[2].blank;
      end
      if (k[1] >= 120 && k[1] < 240) begin
        vs1_act += (obs[1].vs == 1'b0);
        bl1 += obs[1].blank;
      end
      if (obs[1].fs) begin
        fs_cnt++;
        if (fs_last >= 0) chk("fs_spacing", k[1] - fs_last, 120);
        fs_last = k[1];
      end
    end
  endtask

  initial begin
    int n;
    cfg[0] = '{640, 16, 96, 48, 480, 10, 2, 33, 0};
    cfg[1] = '{8, 2, 3, 2, 4, 1, 2, 1, 0};
    cfg[2] = '{320, 16, 96, 48, 240, 10, 2, 33, 1};

    tbl.push_back('{0, 0,   mk(0, 0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 1,   mk(1, 0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 639, mk(639, 0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 640, mk(640, 0, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 655, mk(655, 0, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 656, mk(656, 0, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{0, 751, mk(751, 0, 0, 0, 1, 0, 0, 0)});
    tbl.push_back('{0, 752, mk(752, 0, 0, 1, 1, 0, 0, 0)});
    tbl.push_back('{0, 799, mk(799, 0, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{0, 800, mk(0, 1, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{1, 0,   mk(0, 0, 1, 1, 1, 0, 0, 0)});
    tbl.push_back('{1, 119, mk(14, 7, 0, 1, 1, 1, 0, 0)});
    tbl.push_back('{1, 120, mk(0, 0, 1, 1, 1, 0, 1, 1)});
    tbl.push_back('{1, 30719, mk(14, 7, 0, 1, 1, 1, 0, 255)});
    tbl.push_back('{1, 30720, mk(0, 0, 1, 1, 1, 0, 1, 0)});
    tbl.push_back('{2, 0,   mk(0, 0, 1, 0, 0, 0, 0, 0)});
    tbl.push_back('{2, 320, mk(320, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{2, 335, mk(335, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{2, 336, mk(336, 0, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{2, 431, mk(431, 0, 0, 1, 0, 0, 0, 0)});
    tbl.push_back('{2, 432, mk(432, 0, 0, 0, 0, 0, 0, 0)});
    tbl.push_back('{2, 479, mk(479, 0, 0, 0, 0, 1, 0, 0)});
    tbl.push_back('{2, 480, mk(0, 1, 1, 0, 0, 0, 0, 0)});

    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1;
      k[i] = 0;
    end
    for (int c = 0; c < 3; c++) step();
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    for (int c = 0; c < 30725; c++) step();
    phase_a = 1'b0;

    chk("u0_hs_low_clocks", hs0_act, 96);
    chk("u0_blank_clocks", bl0, 640);
    chk("u0_line_end_count", le0, 1);
    chk("u2_hs_high_clocks", hs2_act, 96);
    chk("u2_blank_clocks", bl2, 320);
    chk("u1_vs_low_clocks", vs1_act, 30);
    chk("u1_blank_clocks", bl1, 32);
    chk("u1_frame_starts", fs_cnt, 256);

    n = 0;
    while (!(obs[1].x == 10'd11 && obs[1].y == 10'd6) && n < 200) begin
      step();
      n++;
    end
    chk("midsync_reached", int'(n < 200), 1);
    chk("midsync_hs_low", int'(obs[1].hs), 0);
    chk("midsync_vs_low", int'(obs[1].vs), 0);

    rst[1] = 1'b1;
    step();
    chk("rst_mid_x", int'(obs[1].x), 0);
    chk("rst_mid_y", int'(obs[1].y), 0);
    chk("rst_mid_hs", int'(obs[1].hs), 1);
    chk("rst_mid_vs", int'(obs[1].vs), 1);
    chk("rst_mid_fc", int'(obs[1].fc), 0);
    chk("rst_mid_fs", int'(obs[1].fs), 0);
    rst[1] = 1'b0;

    n = 0;
    do begin
      step();
      n++;
    end while (obs[1].hs != 1'b0 && n < 100);
    chk("hs_low_after_release", n, 10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
